// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-organised RAM, with programmable OKAY wait
// states and the two-cycle ERROR response for illegal size/alignment combinations.
module ahb_slave_mem #(
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [31:0]       HRDATA
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [MEM_AW-1:0]   widx_q, widx_d;
  logic [1:0]          boff_q, boff_d;
  logic [1:0]          size_q, size_d;
  logic                write_q, write_d;
  logic [3:0]          be;
  logic                accept, size_err;
  logic [31:0]         mem [2**MEM_AW];

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HADDR[ADDR_W-1:MEM_AW+2]};

  assign accept   = HSEL && HREADY && HTRANS[1];
  assign size_err = (HSIZE > 3'd2) || (HSIZE == 3'd1 && HADDR[0]) ||
                    (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    boff_d  = boff_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end with HREADYOUT high, so a new address phase may land here
        state_d = S_IDLE;
        if (accept) begin
          widx_d  = HADDR[MEM_AW+1:2];
          boff_d  = HADDR[1:0];
          size_d  = HSIZE[1:0];
          write_d = HWRITE;
          if (size_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    widx_q  <= widx_d;
    boff_q  <= boff_d;
    size_q  <= size_d;
    write_q <= write_d;
  end

  always_comb begin
    case (size_q)
      2'd0:    be = 4'b0001 << boff_q;
      2'd1:    be = boff_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Commit happens on the edge that ends DATA, so a read accepted on that edge sees new data
  always_ff @(posedge HCLK) begin
    if (HRESETn && state_q == S_DATA && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
  assign HRESP     = (state_q == S_ERR1 || state_q == S_ERR2) ? 2'b01 : 2'b00;
  assign HRDATA    = (state_q == S_DATA && !write_q) ? mem[widx_q] : 32'd0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (0 and 3 wait states) driven in turn by a
// transaction-level master model that predicts every data-phase cycle.
module tb_ahb_slave_mem;
  localparam int MEM_AW = 10;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        hresetn;
  logic        hsel [2];
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hro    [2];
  logic [1:0]  hresp  [2];
  logic [31:0] hrdata [2];

  ahb_slave_mem #(.MEM_AW(MEM_AW), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(hro[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_slave_mem #(.MEM_AW(MEM_AW), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(hro[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  // Master-side view of the outstanding data phase and of the memory contents
  int          cur, ws;
  logic [31:0] mem_m [16];
  bit          started, dp_active, dp_err, dp_write;
  logic [31:0] dp_addr;
  logic [2:0]  dp_size;
  int          dp_idx;
  logic        exp_valid, exp_ready;
  logic [1:0]  exp_resp;
  logic [31:0] exp_rdata;
  int          vectors, miscompares, lowcnt, errcnt;
  logic [31:0] last_rdata;

  always @(negedge clk) begin
    if (exp_valid) begin
      vectors++;
      if (hro[cur] !== exp_ready || hresp[cur] !== exp_resp || hrdata[cur] !== exp_rdata) begin
        miscompares++;
        $display("FAIL cycle dut_ws%0d t=%0t: ready/resp/rdata got %b/%b/%h, expected %b/%b/%h",
                 ws, $time, hro[cur], hresp[cur], hrdata[cur], exp_ready, exp_resp, exp_rdata);
      end
      if (hro[cur] === 1'b0) lowcnt++;
      if (hresp[cur] === 2'b01) errcnt++;
      if (exp_ready && dp_active && !dp_err && !dp_write) last_rdata = hrdata[cur];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s (dut_ws%0d): got %h, expected %h", name, ws, got, exp);
    end
  endtask

  // One bus cycle: drive inputs, publish expectations, then advance the model on the edge
  task automatic cyc(input bit sel, input bit [1:0] trans, input bit wr, input bit [2:0] sz,
                     input bit [31:0] a, input bit [31:0] d, input bit stall, input bit rst);
    bit last;
    exp_valid = started;
    exp_resp  = 2'b00;
    exp_rdata = 32'd0;
    if (!dp_active) begin
      exp_ready = 1'b1;
    end else if (dp_err) begin
      exp_ready = (dp_idx == 1);
      exp_resp  = 2'b01;
    end else begin
      exp_ready = (dp_idx == ws);
      if (dp_idx == ws && !dp_write) exp_rdata = mem_m[dp_addr[5:2]];
    end
    hsel[0] = 1'b0;
    hsel[1] = 1'b0;
    hsel[cur] = sel;
    htrans  = trans;
    hwrite  = wr;
    hsize   = sz;
    haddr   = a;
    hwdata  = d;
    hburst  = 3'($urandom);
    hprot   = 4'($urandom);
    hready  = exp_ready & !stall;
    hresetn = !rst;
    @(posedge clk);
    if (rst) begin
      dp_active = 1'b0;
    end else begin
      if (dp_active) begin
        last = dp_err ? (dp_idx == 1) : (dp_idx == ws);
        if (last && !dp_err && dp_write) begin
          for (int b = 0; b < 4; b++) begin
            if ((dp_size == 3'd0 && b == int'(dp_addr[1:0])) ||
                (dp_size == 3'd1 && (b / 2) == int'(dp_addr[1])) || dp_size == 3'd2)
              mem_m[dp_addr[5:2]][8*b +: 8] = d[8*b +: 8];
          end
        end
        if (last) dp_active = 1'b0;
        else      dp_idx++;
      end
      if (sel && hready && trans[1]) begin
        dp_active = 1'b1;
        dp_idx    = 0;
        dp_write  = wr;
        dp_addr   = a;
        dp_size   = sz;
        dp_err    = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
      end
    end
    started = 1'b1;
    #1;
  endtask

  task automatic xfer(input bit wr, input bit [2:0] sz, input bit [31:0] a, input bit [31:0] d);
    last_rdata = 32'hxxxx_xxxx;
    cyc(1'b1, 2'b10, wr, sz, a, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 20 && dp_active; i++) cyc(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic run_dut(input int which);
    bit [2:0]  sz;
    bit [31:0] a;
    cur = which;
    ws  = which ? 3 : 0;
    started = 1'b0;
    dp_active = 1'b0;
    exp_valid = 1'b0;
    cyc(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(1);
    for (int i = 0; i < 16; i++) xfer(1'b1, 3'd2, 32'(i * 4), 32'hC0DE_0000 + 32'(i));

    // word write then read back, plus wait-state count on the read
    xfer(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    lowcnt = 0;
    xfer(1'b0, 3'd2, 32'h10, 32'h0);
    chk("word_readback", last_rdata, 32'hDEAD_BEEF);
    chk("read_wait_cycles", 32'(lowcnt), 32'(ws));

    // byte and halfword merges into an existing word
    xfer(1'b1, 3'd2, 32'h10, 32'h1122_3344);
    xfer(1'b1, 3'd0, 32'h13, 32'hAA5A_5A5A);
    xfer(1'b0, 3'd2, 32'h10, 32'h0);
    chk("byte_merge", last_rdata, 32'hAA22_3344);
    xfer(1'b1, 3'd1, 32'h12, 32'h5566_C3C3);
    xfer(1'b0, 3'd2, 32'h10, 32'h0);
    chk("half_merge", last_rdata, 32'h5566_3344);

    // misaligned word write and oversize read both error without touching memory
    errcnt = 0;
    xfer(1'b1, 3'd2, 32'h02, 32'hFFFF_FFFF);
    chk("err_cycles_misaligned", 32'(errcnt), 32'd2);
    errcnt = 0;
    xfer(1'b0, 3'd3, 32'h00, 32'h0);
    chk("err_cycles_oversize", 32'(errcnt), 32'd2);
    xfer(1'b0, 3'd2, 32'h00, 32'h0);
    chk("err_no_write", last_rdata, 32'hC0DE_0000);

    // stalled bus and BUSY are not accepted
    cyc(1'b1, 2'b10, 1'b1, 3'd2, 32'h00, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 3'd2, 32'h00, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(1);
    xfer(1'b0, 3'd2, 32'h00, 32'h0);
    chk("no_accept_no_write", last_rdata, 32'hC0DE_0000);

    // reset during an in-flight write abandons it
    cyc(1'b1, 2'b10, 1'b1, 3'd2, 32'h04, 32'h1234_5678, 1'b0, 1'b0);
    for (int i = 0; i < ws; i++) cyc(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'h1234_5678, 1'b0, 1'b1);
    idle(1);
    xfer(1'b0, 3'd2, 32'h04, 32'h0);
    chk("reset_abandons_write", last_rdata, 32'hC0DE_0001);

    // randomized pipelined traffic
    for (int i = 0; i < 600; i++) begin
      sz = ($urandom_range(0, 7) < 7) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
      end
      cyc($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), sz, a, $urandom,
          $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end
    idle(ws + 3);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    lowcnt = 0;
    errcnt = 0;
    run_dut(0);
    run_dut(1);
    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
